// File: rtl/seq_alu_if.sv
// Request/response bundle between pipeline control and seq_alu.
// master drives the operation request; slave returns results and status.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             zero;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, a, b,
        input  result, hi, carry, zero, div_by_zero, busy, done
    );

    modport slave (
        input  start, alu_op, a, b,
        output result, hi, carry, zero, div_by_zero, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Execute-stage ALU: logic/add/sub/div-by-zero in 1 edge, MUL/DIV WIDTH+1 edges.
// start is ignored while busy; callers stall on busy and consume results on done.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   alu_if
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   hi_q;
    logic               carry_q;
    logic               zero_q;
    logic               dbz_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     add_d;
    logic [WIDTH:0]     sub_d;
    logic [WIDTH-1:0]   sc_res_d;
    logic [WIDTH-1:0]   sc_hi_d;
    logic               sc_carry_d;
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     div_shift_d;
    logic [WIDTH:0]     div_diff_d;
    logic [2*WIDTH-1:0] div_acc_d;
    logic               last_step;

    always_comb begin
        add_d      = {1'b0, alu_if.a} + {1'b0, alu_if.b};
        sub_d      = {1'b0, alu_if.a} - {1'b0, alu_if.b};
        sc_res_d   = '0;
        sc_hi_d    = '0;
        sc_carry_d = 1'b0;
        case (alu_if.alu_op)
            OP_ADD: begin sc_res_d = add_d[WIDTH-1:0]; sc_carry_d = add_d[WIDTH]; end
            OP_SUB: begin sc_res_d = sub_d[WIDTH-1:0]; sc_carry_d = sub_d[WIDTH]; end
            OP_AND: sc_res_d = alu_if.a & alu_if.b;
            OP_OR:  sc_res_d = alu_if.a | alu_if.b;
            OP_XOR: sc_res_d = alu_if.a ^ alu_if.b;
            OP_DIV: begin sc_res_d = '1; sc_hi_d = alu_if.a; end
            default: sc_res_d = ~alu_if.a;
        endcase

        // Multiply: upper half accumulates, whole register shifts right each step.
        mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (opb_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};

        // Divide: upper half is the remainder, lower half shifts dividend out / quotient in.
        div_shift_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, opb_q};
        if (div_diff_d[WIDTH])
            div_acc_d = {div_shift_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_acc_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (alu_if.start) begin
                        if (alu_if.alu_op == OP_MUL) begin
                            opa_q   <= alu_if.a;
                            opb_q   <= alu_if.b;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MUL_ITER;
                        end else if (alu_if.alu_op == OP_DIV && alu_if.b != '0) begin
                            opb_q   <= alu_if.b;
                            acc_q   <= {{WIDTH{1'b0}}, alu_if.a};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= DIV_ITER;
                        end else begin
                            result_q <= sc_res_d;
                            hi_q     <= sc_hi_d;
                            carry_q  <= sc_carry_d;
                            zero_q   <= (sc_res_d == '0);
                            dbz_q    <= (alu_if.alu_op == OP_DIV);
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL_ITER: begin
                    acc_q <= mul_acc_d;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        result_q <= mul_acc_d[WIDTH-1:0];
                        hi_q     <= mul_acc_d[2*WIDTH-1:WIDTH];
                        carry_q  <= 1'b0;
                        zero_q   <= (mul_acc_d[WIDTH-1:0] == '0);
                        dbz_q    <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                DIV_ITER: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        result_q <= div_acc_d[WIDTH-1:0];
                        hi_q     <= div_acc_d[2*WIDTH-1:WIDTH];
                        carry_q  <= 1'b0;
                        zero_q   <= (div_acc_d[WIDTH-1:0] == '0);
                        dbz_q    <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_if.result      = result_q;
    assign alu_if.hi          = hi_q;
    assign alu_if.carry       = carry_q;
    assign alu_if.zero        = zero_q;
    assign alu_if.div_by_zero = dbz_q;
    assign alu_if.busy        = busy_q;
    assign alu_if.done        = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expectations queued at issue, checked by a done-driven monitor.
module tb_seq_alu;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    seq_alu_if #(.WIDTH(16)) bus ();
    seq_alu #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .alu_if(bus));

    typedef struct {
        string       nm;
        logic [15:0] res;
        logic [15:0] hi;
        logic        c;
        logic        z;
        logic        dbz;
    } exp_t;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done && bus.busy)
                chk("done_with_busy", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.nm, ".result"}, bus.result, e.res);
                    chk({e.nm, ".hi"}, bus.hi, e.hi);
                    chk({e.nm, ".carry"}, bus.carry, e.c);
                    chk({e.nm, ".zero"}, bus.zero, e.z);
                    chk({e.nm, ".dbz"}, bus.div_by_zero, e.dbz);
                end
            end
        end
    end

    // Called at a negedge: drives the request for one edge and queues the expectation.
    task automatic issue(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                         input string nm, input logic [15:0] r, input logic [15:0] h,
                         input logic c, input logic dz);
        exp_t e;
        e.nm = nm; e.res = r; e.hi = h; e.c = c; e.z = (r == 16'h0); e.dbz = dz;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.a      = av;
        bus.b      = bv;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (bus.busy) chk({nm, ".timeout"}, 1, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".result"}, bus.result, 16'h0);
        chk({nm, ".hi"}, bus.hi, 16'h0);
        chk({nm, ".carry"}, bus.carry, 0);
        chk({nm, ".zero"}, bus.zero, 1);
        chk({nm, ".dbz"}, bus.div_by_zero, 0);
        chk({nm, ".busy"}, bus.busy, 0);
        chk({nm, ".done"}, bus.done, 0);
    endtask

    initial begin
        int cyc;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.alu_op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b100, 16'hF0F0, 16'hFF00, "and", 16'hF000, 16'h0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 16'hFFFF, 16'h0001, "add_wrap", 16'h0000, 16'h0, 1, 0);
        issue(3'b001, 16'd3, 16'd5, "sub_borrow", 16'hFFFE, 16'h0, 1, 0);
        issue(3'b101, 16'hF0F0, 16'hFF00, "or", 16'hFFF0, 16'h0, 0, 0);
        issue(3'b110, 16'hF0F0, 16'hFF00, "xor", 16'h0FF0, 16'h0, 0, 0);
        issue(3'b111, 16'h00FF, 16'h1234, "not", 16'hFF00, 16'h0, 0, 0);

        // MUL with an ADD request mid-iteration that must be dropped.
        issue(3'b010, 16'd300, 16'd500, "mul", 16'h49F0, 16'h0002, 0, 0);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (cyc == 4) begin
                bus.start = 1'b1; bus.alu_op = 3'b000; bus.a = 16'd1; bus.b = 16'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("mul.busy_cycles", cyc, 16);
        chk("mul.done_after_busy", bus.done, 1);

        issue(3'b010, 16'hFFFF, 16'hFFFF, "mul_max", 16'h0001, 16'hFFFE, 0, 0);
        wait_idle("mul_max", cyc);

        issue(3'b011, 16'd1000, 16'd7, "div", 16'h008E, 16'h0006, 0, 0);
        wait_idle("div", cyc);
        chk("div.busy_cycles", cyc, 16);

        issue(3'b011, 16'd5, 16'd9, "div_small", 16'h0000, 16'h0005, 0, 0);
        wait_idle("div_small", cyc);

        issue(3'b011, 16'h1234, 16'h0000, "div0", 16'hFFFF, 16'h1234, 0, 1);
        chk("div0.busy", bus.busy, 0);
        issue(3'b000, 16'd10, 16'd20, "add_clr_dbz", 16'd30, 16'h0, 0, 0);
        @(negedge clk);

        // Reset during MUL: pending expectation is discarded, no done may follow.
        issue(3'b010, 16'd300, 16'd500, "mul_abort", 16'h49F0, 16'h0002, 0, 0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_mid_mul");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(3'b000, 16'd2, 16'd2, "add_after_abort", 16'd4, 16'h0, 0, 0);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle execute-stage ALU for the CPU datapath. It consumes the 3-bit `alu_op` produced by ALU control, along with the two register/immediate operands. Logic and add/sub operations complete in one clock. MUL and DIV run iteratively, one bit per clock, behind a start/busy/done handshake that the pipeline control uses to stall.

## Interface
- `WIDTH`, default 16: operand and result width. Must be at least 2.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: operation request. Sampled only when `busy`=0.
- `alu_op`, input, 3: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned.
- `result`, output, WIDTH: primary result. For MUL, the low product half. For DIV, the quotient.
- `hi`, output, WIDTH: high product half for MUL, remainder for DIV. 0 for all other ops.
- `carry`, output, 1: ADD carry-out, or SUB borrow (a<b). 0 for other ops.
- `zero`, output, 1: `result`==0.
- `div_by_zero`, output, 1: the last DIV had b==0.
- `busy`, output, 1: a MUL/DIV iteration is in progress.
- `done`, output, 1: one-cycle pulse marking the edge at which the outputs updated.

## Operation
- States: IDLE, MUL_ITER, DIV_ITER. Iteration counter is clog2(WIDTH)+1 bits.
- IDLE with `start`=1 and a single-cycle op (ADD, SUB, AND, OR, XOR, NOT):
  - On that edge, `result`/`hi`/`carry`/`zero` are registered and `done`=1.
  - The block stays in IDLE.
- Single-cycle op rules:
  - NOT is ~a; `b` is ignored.
  - ADD/SUB arithmetic is modulo 2^WIDTH; `carry` is bit WIDTH of the (WIDTH+1)-bit sum/difference.
  - `div_by_zero` is cleared by any completed non-DIV op.
- IDLE with `start`=1 and MUL:
  - Latch a and b, clear the 2·WIDTH accumulator, set `busy`=1, go to MUL_ITER.
  - Each MUL_ITER edge performs one shift-add step (LSB of the multiplier first).
  - After WIDTH steps: write {hi,result} = a·b, `carry`=0, pulse `done`, clear `busy`, return to IDLE.
- IDLE with `start`=1 and DIV, b≠0:
  - Latch operands, `busy`=1, go to DIV_ITER.
  - WIDTH restoring-division steps, MSB first.
  - Final edge writes quotient→`result`, remainder→`hi`, `div_by_zero`=0, `done`=1.
- DIV with b==0:
  - Completes in one edge like a single-cycle op; no iteration.
  - `result`={WIDTH{1}}, `hi`=a, `div_by_zero`=1.
- `start` while `busy`=1 is ignored. Operands and `alu_op` are don't-care during iteration; the latched copies are used.
- Outputs hold their last values until the next completion; only `done` self-clears.
- `zero` always reflects the registered `result`, including after MUL/DIV.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0.
  - `result`=0, `hi`=0, `carry`=0, `zero`=1, `div_by_zero`=0, `busy`=0, `done`=0.
- Reset mid-iteration aborts the operation: no `done` pulse, partial results are discarded.
- Single-cycle op latency: 1 edge, with `done` high in the cycle after the sampling edge.
- MUL/DIV latency (b≠0): WIDTH+1 edges.
  - `busy` is high for exactly WIDTH cycles.
  - `done` rises on the same edge `busy` falls.
- Back-to-back: `start` in the same cycle `done` is high is accepted, since the block is in IDLE. Zero bubble between operations.
- `done` never coincides with `busy`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle.
  - Outputs go to their reset values without a clock.
  - `zero`=1, `busy`=0.
- **ADD wrap (WIDTH=16):** a=0xFFFF, b=0x0001.
  - After 1 edge: `result`=0x0000, `carry`=1, `zero`=1, `done`=1 pulse.
- **SUB borrow:** a=3, b=5.
  - `result`=0xFFFE, `carry`=1.
- **MUL:** a=300, b=500.
  - `busy` high for 16 cycles, `done` on edge 17.
  - `hi`=0x0002, `result`=0x49F0.
  - A `start` pulse with ADD issued at cycle 5 is ignored.
- **DIV:** a=1000, b=7.
  - After 17 edges: `result`=0x008E, `hi`=0x0006, `div_by_zero`=0.
- **DIV by zero:** a=0x1234, b=0.
  - After 1 edge: `result`=0xFFFF, `hi`=0x1234, `div_by_zero`=1, `busy` never asserted.
- **Reset mid-MUL:** drop `rst_n` at iteration 8.
  - No `done` pulse; state returns to IDLE.
  - A new ADD 2+2 then gives `result`=4 one edge later.
